// File: rtl/vga_vram_arbiter_if.sv
// Signal bundle between the VGA execute stage, scan controller, VRAM and the arbiter.
// slave modport is the arbiter side; master modport is the surrounding system side.
interface vga_vram_arbiter_if #(
   parameter int unsigned COLOR_W = 3,
   parameter int unsigned COORD_W = 8,
   parameter int unsigned ADDR_W  = 10
);
   logic               wr_valid;
   logic [COLOR_W-1:0] color;
   logic [COORD_W-1:0] row;
   logic [COORD_W-1:0] col;
   logic               wr_ready;
   logic               scan_req;
   logic [ADDR_W-1:0]  scan_addr;
   logic               scan_valid;
   logic [COLOR_W-1:0] scan_data;
   logic [ADDR_W-1:0]  vram_addr;
   logic               vram_we;
   logic [COLOR_W-1:0] vram_wdata;
   logic [COLOR_W-1:0] vram_rdata;
   logic               busy;
   logic               oob_err;

   modport slave (
      input  wr_valid, color, row, col, scan_req, scan_addr, vram_rdata,
      output wr_ready, scan_valid, scan_data, vram_addr, vram_we, vram_wdata, busy, oob_err
   );

   modport master (
      output wr_valid, color, row, col, scan_req, scan_addr, vram_rdata,
      input  wr_ready, scan_valid, scan_data, vram_addr, vram_we, vram_wdata, busy, oob_err
   );
endinterface

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: scan reads have strict priority, CPU pixel writes are FIFO-buffered.
// Define VGA_VRAM_ARB_BOUNDS_EN to discard out-of-range writes and flag them on oob_err.
module vga_vram_arbiter #(
   parameter int unsigned COLOR_W    = 3,
   parameter int unsigned COORD_W    = 8,
   parameter int unsigned COLS       = 32,
   parameter int unsigned ROWS       = 32,
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input logic                clk,
   input logic                rst_n,
   vga_vram_arbiter_if.slave  bus
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned ENT_W = ADDR_W + COLOR_W;

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} grant_t;

   logic [ENT_W-1:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count;
   logic [ADDR_W-1:0]  enq_addr;
   logic               full, empty, push, store, pop;
   grant_t             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [COLOR_W-1:0] wdata_q, wdata_d;
   logic               rd_pend, scan_valid_q;
   logic [COLOR_W-1:0] scan_data_q;

   assign full     = (count == CNT_W'(FIFO_DEPTH));
   assign empty    = (count == '0);
   assign push     = bus.wr_valid & ~full;
   assign enq_addr = ADDR_W'(32'(bus.row) * COLS + 32'(bus.col));

`ifdef VGA_VRAM_ARB_BOUNDS_EN
   logic in_range, oob_q;
   assign in_range = (32'(bus.row) < ROWS) && (32'(bus.col) < COLS);
   // Out-of-range writes still complete the handshake; they are just not stored.
   assign store    = push & in_range;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                oob_q <= 1'b0;
      else if (push & ~in_range) oob_q <= 1'b1;
   end
   assign bus.oob_err = oob_q;
`else
   assign store       = push;
   assign bus.oob_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (store) mem[wr_ptr] <= {enq_addr, bus.color};
   end

   always_comb begin
      state_d = S_IDLE;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      pop     = 1'b0;
      if (bus.scan_req) begin
         state_d = S_RD;
         addr_d  = bus.scan_addr;
      end else if (!empty) begin
         state_d = S_WR;
         pop     = 1'b1;
         addr_d  = mem[rd_ptr][ENT_W-1:COLOR_W];
         wdata_d = mem[rd_ptr][COLOR_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         if (store) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({store, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Read address goes out after the grant edge; RAM data is captured one edge later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend      <= 1'b0;
         scan_valid_q <= 1'b0;
         scan_data_q  <= '0;
      end else begin
         rd_pend      <= (state_q == S_RD);
         scan_valid_q <= rd_pend;
         if (rd_pend) scan_data_q <= bus.vram_rdata;
      end
   end

   assign bus.wr_ready   = ~full;
   assign bus.busy       = ~empty;
   assign bus.vram_addr  = addr_q;
   assign bus.vram_we    = (state_q == S_WR);
   assign bus.vram_wdata = wdata_q;
   assign bus.scan_valid = scan_valid_q;
   assign bus.scan_data  = scan_data_q;
endmodule
